awgn_stat_monitor: RTL and testbench
====================================

# awgn_stat_monitor

Block-level statistics collector that consumes the paired Gaussian noise samples (x0, x1) produced by the AWGN generator and reduces a block of N = 2^LOG2_N sample pairs to per-channel sum, sum of squares and outlier count. It is the receiving end of the generator's sample stream and sits between the noise core and the host/testbench readout. It supports on-chip checks of mean, variance and tail behaviour without exporting raw samples.

## Interface
- LOG2_N, default 10: log2 of the number of sample pairs per measurement block (1..16).
- W, default 16: sample width, signed two's complement.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a block; honoured only in IDLE.
- threshold  in  W  unsigned magnitude threshold for outlier counting; sampled on an accepted start.
- in_valid  in  1  x0/x1 pair present.
- in_ready  out  1  block accepts a pair this cycle.
- x0, x1  in  W each  signed noise samples.
- busy  out  1  high in ACCUM and REPORT.
- out_valid  out  1  results valid; held until out_ready.
- out_ready  in  1  consumer accepts the results.
- sum0, sum1  out  W+LOG2_N each  signed sums of x0 and x1.
- sumsq0, sumsq1  out  2W+LOG2_N each  unsigned sums of squares.
- outliers  out  LOG2_N+2  count of samples, across both channels, with |x| >= threshold.

## Operation
- States: IDLE, ACCUM, REPORT.
- IDLE: in_ready=0, out_valid=0, busy=0. start=1 clears all accumulators and the pair counter, latches threshold, and moves to ACCUM. The result outputs keep the previous block's values until that clear.
- ACCUM: in_ready=1, busy=1. Each cycle with in_valid && in_ready, the block accepts one pair:
  - sumN += sign-extended xN;
  - sumsqN += xN*xN, a full signed 2W-bit product, zero-extended;
  - outliers += (|x0| >= thr) + (|x1| >= thr).
- Magnitude is computed at W+1 bits, so |-2^(W-1)| = 2^(W-1) and never wraps to negative. Accumulator widths are sized so that no overflow is possible for any input.
- The pair counter is LOG2_N bits. When the accepted pair is number N-1 (counter all-ones), the state moves to REPORT on that same edge and the counter wraps to 0.
- in_valid low in ACCUM is a gap: nothing changes and there is no timeout.
- REPORT: in_ready=0, busy=1, out_valid=1. The result outputs are stable. out_valid && out_ready moves the state to IDLE.
- start outside IDLE is ignored, including start in the same cycle as the REPORT handshake. A new block requires start while in IDLE.
- Reset in any state: state=IDLE; all accumulators, counter and outputs are 0; the latched threshold is 0.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=0, sum0=sum1=0, sumsq0=sumsq1=0, outliers=0.
- All outputs are registered or decoded from the state register only. There is no combinational path from in_valid or out_ready to any output.
- start accepted at edge k: in_ready=1 from cycle k+1.
- Accumulation latency is 1 cycle. A pair accepted at edge k is reflected in the accumulators after edge k.
- The last pair accepted at edge k gives out_valid=1 in cycle k+1 with final values.
- Minimum block duration is 1 + N + 1 cycles: start, N accepts, 1 REPORT handshake cycle.
- Handshake at edge j in REPORT gives out_valid=0 and busy=0 from cycle j+1. The earliest new start is accepted at edge j+1.

## Test plan
All scenarios use LOG2_N=2 (N=4) and W=16.
- **Constant input:** threshold=100, 4 pairs x0=100, x1=-100 -> sum0=400, sum1=-400, sumsq0=sumsq1=40000, outliers=8. Repeating with threshold=101 gives outliers=0.
- **Extreme values:** 4 pairs x0=-32768, x1=32767, threshold=32767 -> sum0=-131072, sum1=131068, sumsq0=4294967296, sumsq1=4294705156, outliers=8. No wrap occurs.
- **Flow control:** in_valid toggled 1,0,0,1,1,0,1 with pairs (1,-1),(2,-2),(3,-3),(4,-4) -> sum0=10, sum1=-10, sumsq0=sumsq1=30. out_valid rises exactly one cycle after the 4th accept. Holding out_ready=0 for 5 cycles keeps out_valid high with stable values. Then out_ready=1 returns the block to IDLE next cycle.
- **start while busy:** start pulsed during ACCUM after 2 pairs and again during REPORT -> both ignored. Counts complete on the original block, and the block returns to IDLE only via the handshake.
- **Reset mid-block:** reset after 2 accepted pairs -> next cycle all outputs are 0 and in_ready=0. A new start followed by 4 pairs of (5,5), threshold=0 -> sum0=sum1=20, sumsq0=sumsq1=100, outliers=8.
- **Back-to-back blocks:** start issued the cycle after the REPORT handshake -> accepted. Previous results stay visible until that edge, then clear to 0.

Source files
------------

// File: rtl/awgn_stat_monitor.sv
// awgn_stat_monitor: reduces a block of 2^LOG2_N (x0, x1) noise pairs to
// per-channel sum, sum of squares and a shared |x| >= threshold count.
// Results stay on the outputs until the next accepted start clears them.

// Per-channel accumulator: signed sum, unsigned sum of squares, outlier hit.
module awgn_stat_chan #(
  parameter int LOG2_N = 10,
  parameter int W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    acc_en,
  input  logic [W-1:0]            x,
  input  logic [W-1:0]            thr,
  output logic                    hit,
  output logic [W+LOG2_N-1:0]     sum,
  output logic [2*W+LOG2_N-1:0]   sumsq
);
  logic [W:0]            x_ext;
  logic [W:0]            mag;
  logic signed [2*W-1:0] prod;

  // Magnitude at W+1 bits so the most negative sample does not wrap.
  always_comb begin
    x_ext = {x[W-1], x};
    mag   = x[W-1] ? (~x_ext + (W+1)'(1)) : x_ext;
    hit   = (mag >= {1'b0, thr});
    prod  = $signed(x) * $signed(x);
  end

  // Accumulate on every accepted pair; clear on a new block.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sum   <= '0;
      sumsq <= '0;
    end else if (acc_en) begin
      sum   <= sum + {{LOG2_N{x[W-1]}}, x};
      sumsq <= sumsq + {{LOG2_N{1'b0}}, prod};
    end
  end
endmodule

module awgn_stat_monitor #(
  parameter int LOG2_N = 10,
  parameter int W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [W-1:0]            threshold,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            x0,
  input  logic [W-1:0]            x1,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W+LOG2_N-1:0]     sum0,
  output logic [W+LOG2_N-1:0]     sum1,
  output logic [2*W+LOG2_N-1:0]   sumsq0,
  output logic [2*W+LOG2_N-1:0]   sumsq1,
  output logic [LOG2_N+1:0]       outliers
);
  localparam int NUM_CH = 2;

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  state_t                                 state_q, state_d;
  logic [LOG2_N-1:0]                      cnt_q;
  logic [W-1:0]                           thr_q;
  logic                                   clr, accept, last;
  logic [NUM_CH-1:0][W-1:0]               xs;
  logic [NUM_CH-1:0]                      hit;
  logic [NUM_CH-1:0][W+LOG2_N-1:0]        sum_a;
  logic [NUM_CH-1:0][2*W+LOG2_N-1:0]      sumsq_a;

  assign xs       = {x1, x0};
  assign sum0     = sum_a[0];
  assign sum1     = sum_a[1];
  assign sumsq0   = sumsq_a[0];
  assign sumsq1   = sumsq_a[1];

  // Handshake qualifiers, all gated by the registered state.
  always_comb begin
    clr    = (state_q == IDLE) && start;
    accept = (state_q == ACCUM) && in_valid;
    last   = accept && (&cnt_q);
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last) state_d = REPORT;
      end
      REPORT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Pair counter wraps to zero on the last pair; threshold latched on start.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      thr_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
      thr_q <= threshold;
    end else if (accept) begin
      cnt_q <= cnt_q + LOG2_N'(1);
    end
  end

  // Outlier count spans both channels.
  always_ff @(posedge clk) begin
    if (reset || clr)
      outliers <= '0;
    else if (accept)
      outliers <= outliers + (LOG2_N+2)'(hit[0]) + (LOG2_N+2)'(hit[1]);
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    awgn_stat_chan #(.LOG2_N(LOG2_N), .W(W)) u_chan (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr),
      .acc_en (accept),
      .x      (xs[ch]),
      .thr    (thr_q),
      .hit    (hit[ch]),
      .sum    (sum_a[ch]),
      .sumsq  (sumsq_a[ch])
    );
  end
endmodule

// File: tb/tb_awgn_stat_monitor.sv
// Bench for awgn_stat_monitor at LOG2_N=2, W=16: table of blocks with
// expected results queued at start and compared when out_valid appears,
// plus hand sequences for start-while-busy, mid-block reset, back-to-back.
module tb_awgn_stat_monitor;
  localparam int LOG2_N = 2;
  localparam int W      = 16;
  localparam int N      = 4;

  logic                  clk = 1'b0;
  logic                  reset, start, in_valid, out_ready;
  logic [W-1:0]          threshold, x0, x1;
  logic                  in_ready, busy, out_valid;
  logic [W+LOG2_N-1:0]   sum0, sum1;
  logic [2*W+LOG2_N-1:0] sumsq0, sumsq1;
  logic [LOG2_N+1:0]     outliers;

  awgn_stat_monitor #(.LOG2_N(LOG2_N), .W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .threshold(threshold),
    .in_valid(in_valid), .in_ready(in_ready), .x0(x0), .x1(x1),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .sum0(sum0), .sum1(sum1), .sumsq0(sumsq0), .sumsq1(sumsq1),
    .outliers(outliers)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]          thr;
    logic [N-1:0][W-1:0]   x0;
    logic [N-1:0][W-1:0]   x1;
    longint                s0, s1, q0, q1, ol;
  } vec_t;

  typedef struct { longint s0, s1, q0, q1, ol; } exp_t;

  exp_t sb[$];
  vec_t tbl[5];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic exp_t model(input vec_t v);
    exp_t e;
    longint a, b;
    e = '{0, 0, 0, 0, 0};
    for (int i = 0; i < N; i++) begin
      a = longint'($signed(v.x0[i]));
      b = longint'($signed(v.x1[i]));
      e.s0 += a;
      e.s1 += b;
      e.q0 += a * a;
      e.q1 += b * b;
      e.ol += ((a < 0 ? -a : a) >= longint'(v.thr)) ? 1 : 0;
      e.ol += ((b < 0 ? -b : b) >= longint'(v.thr)) ? 1 : 0;
    end
    return e;
  endfunction

  function automatic exp_t tbl_exp(input vec_t v);
    exp_t e;
    e = '{v.s0, v.s1, v.q0, v.q1, v.ol};
    return e;
  endfunction

  task automatic chk_zero(input string nm);
    chk({nm, "_sum0"}, longint'($signed(sum0)), 0);
    chk({nm, "_sum1"}, longint'($signed(sum1)), 0);
    chk({nm, "_sumsq0"}, longint'(sumsq0), 0);
    chk({nm, "_sumsq1"}, longint'(sumsq1), 0);
    chk({nm, "_outliers"}, longint'(outliers), 0);
  endtask

  task automatic do_start(input logic [W-1:0] thr);
    start = 1'b1;
    threshold = thr;
    tick();
    start = 1'b0;
    chk("start_in_ready", longint'(in_ready), 1);
    chk("start_busy", longint'(busy), 1);
    chk_zero("start_clear");
  endtask

  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b, input int gap);
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    in_valid = 1'b1;
    x0 = a;
    x1 = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for results, compare with the queue head, optionally hold
  // out_ready low, then handshake and confirm the return to IDLE.
  task automatic get_result(input int hold, input bit handshake);
    exp_t e;
    int   n;
    logic [W+LOG2_N-1:0]   s0_hold;
    logic [2*W+LOG2_N-1:0] q1_hold;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("result_wait", longint'(out_valid), 1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("res_sum0", longint'($signed(sum0)), e.s0);
    chk("res_sum1", longint'($signed(sum1)), e.s1);
    chk("res_sumsq0", longint'(sumsq0), e.q0);
    chk("res_sumsq1", longint'(sumsq1), e.q1);
    chk("res_outliers", longint'(outliers), e.ol);
    chk("report_in_ready", longint'(in_ready), 0);
    chk("report_busy", longint'(busy), 1);
    s0_hold = sum0;
    q1_hold = sumsq1;
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_out_valid", longint'(out_valid), 1);
      chk("hold_sum0", longint'(sum0), longint'(s0_hold));
      chk("hold_sumsq1", longint'(sumsq1), longint'(q1_hold));
    end
    if (handshake) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("post_hs_out_valid", longint'(out_valid), 0);
      chk("post_hs_busy", longint'(busy), 0);
      chk("idle_keeps_sum0", longint'($signed(sum0)), e.s0);
    end
  endtask

  task automatic run_vec(input vec_t v, input exp_t e, input logic [N-1:0][3:0] gaps, input int hold);
    sb.push_back(e);
    do_start(v.thr);
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) chk("pre_last_out_valid", longint'(out_valid), 0);
      send_pair(v.x0[i], v.x1[i], int'(gaps[i]));
    end
    chk("last_accept_out_valid", longint'(out_valid), 1);
    get_result(hold, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    // Constant input, threshold hit exactly.
    tbl[0] = '{16'd100, {4{16'd100}}, {4{16'hFF9C}}, 400, -400, 40000, 40000, 8};
    // Same data, threshold one above.
    tbl[1] = '{16'd101, {4{16'd100}}, {4{16'hFF9C}}, 400, -400, 40000, 40000, 0};
    // Extreme values.
    tbl[2] = '{16'd32767, {4{16'h8000}}, {4{16'h7FFF}},
               -131072, 131068, 64'd4294967296, 64'd4294705156, 8};
    // Flow-control data (1..4, -1..-4), threshold 3 hits 3 and 4 per channel.
    tbl[3] = '{16'd3, {16'd4, 16'd3, 16'd2, 16'd1},
               {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF}, 10, -10, 30, 30, 4};
    // After mid-block reset: (5,5) with threshold 0.
    tbl[4] = '{16'd0, {4{16'd5}}, {4{16'd5}}, 20, 20, 100, 100, 8};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    threshold = '0; x0 = '0; x1 = '0;
    tick(); tick();
    chk("reset_in_ready", longint'(in_ready), 0);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_busy", longint'(busy), 0);
    chk_zero("reset");
    reset = 1'b0;
    tick();

    // Constant input, then back-to-back start right after the handshake.
    run_vec(tbl[0], tbl_exp(tbl[0]), '0, 0);
    run_vec(tbl[1], tbl_exp(tbl[1]), '0, 0);
    run_vec(tbl[2], tbl_exp(tbl[2]), '0, 1);
    // in_valid pattern 1,0,0,1,1,0,1 with a 5-cycle out_ready stall.
    run_vec(tbl[3], tbl_exp(tbl[3]), {4'd1, 4'd0, 4'd2, 4'd0}, 5);

    // start while busy: ignored in ACCUM, in REPORT and on the handshake edge.
    v = '{16'd7, {16'd0, 16'hFFEC, 16'd7, 16'd10},
          {16'd1, 16'd4, 16'd7, 16'hFFFD}, 0, 0, 0, 0, 0};
    sb.push_back(model(v));
    do_start(v.thr);
    send_pair(v.x0[0], v.x1[0], 0);
    send_pair(v.x0[1], v.x1[1], 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_in_ready", longint'(in_ready), 1);
    send_pair(v.x0[2], v.x1[2], 0);
    send_pair(v.x0[3], v.x1[3], 0);
    chk("busy_last_out_valid", longint'(out_valid), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("report_start_out_valid", longint'(out_valid), 1);
    get_result(0, 1'b0);
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    chk("hs_start_busy", longint'(busy), 0);
    chk("hs_start_in_ready", longint'(in_ready), 0);
    tick();
    chk("hs_start_still_idle", longint'(busy), 0);

    // Reset mid-block after 2 pairs.
    do_start(16'd50);
    send_pair(16'd3, 16'd3, 0);
    send_pair(16'd3, 16'd3, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_in_ready", longint'(in_ready), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk_zero("midrst");
    run_vec(tbl[4], tbl_exp(tbl[4]), '0, 0);

    // Random blocks against the reference model.
    for (int r = 0; r < 4; r++) begin
      v.thr = W'($urandom_range(0, 32768));
      for (int i = 0; i < N; i++) begin
        v.x0[i] = W'($urandom);
        v.x1[i] = W'($urandom);
      end
      run_vec(v, model(v), {4'(r % 2), 4'(0), 4'(r % 3), 4'(0)}, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
